alu_seq: RTL

Parametrised, handshaked successor to the 16-bit combinational ALU. It keeps the same opcode encoding and five-flag layout, but adds a generic data width, a registered result with valid/ready flow control, persistent flag storage and iterative multi-cycle shifts. It sits between the decode stage and the register-file write-back path of the CPU datapath.

---
 rtl/alu_seq_pkg.sv | 47 ++++
 rtl/alu_iter_shift.sv | 76 +++++++
 rtl/alu_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU (alu_seq) and its iterative shifter.
//   - 8-bit opcode encodings (same encoding as the 16-bit combinational ALU)
//   - flag bit positions inside the 5-bit flags word
//   - FSM state encoding
//   - small decode helpers
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcodes
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;
  localparam logic [7:0] OP_MUL  = 8'h0E;

  // Flag bit indices within flags[4:0]
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True for the two iterative shift opcodes.
  function automatic logic is_shift_op(input logic [7:0] op);
    return (op == OP_LSH) || (op == OP_ASHU);
  endfunction

  // True when a right shift must replicate the MSB.
  function automatic logic is_arith_op(input logic [7:0] op);
    return (op == OP_ASHU);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_iter_shift.sv
// -----------------------------------------------------------------------------
// alu_iter_shift
// Iterative one-bit-per-cycle shifter used by alu_seq for LSH / ASHU.
//
// A pulse on `start` loads the operand, the saturated shift magnitude and the
// direction/arithmetic controls. On every following cycle with a nonzero
// counter the register shifts by one bit and the counter decrements. `done`
// is high during the cycle whose closing edge performs the last shift, and
// `data_next` carries the value that edge will produce, so the controller can
// capture the final result and leave its SHIFT state on the same edge.
//
// Parameters
//   WIDTH     operand width
//   CNT_W     magnitude counter width (must hold WIDTH)
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   load operand and controls (one-cycle pulse)
//   din        in   operand to shift
//   mag        in   shift magnitude, already saturated to WIDTH, nonzero
//   dir_right  in   1 = shift right, 0 = shift left
//   arith      in   right shifts replicate the MSB
//   done       out  the coming edge performs the final shift
//   data_next  out  register value after the coming edge's shift
// -----------------------------------------------------------------------------
module alu_iter_shift
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] mag,
  input  logic             dir_right,
  input  logic             arith,
  output logic             done,
  output logic [WIDTH-1:0] data_next
);

  logic [WIDTH-1:0] sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             right_q;
  logic             arith_q;
  logic             fill_bit;

  // Bit shifted in at the top on a right shift.
  assign fill_bit  = arith_q & sh_q[WIDTH-1];

  assign data_next = right_q ? {fill_bit, sh_q[WIDTH-1:1]}
                             : {sh_q[WIDTH-2:0], 1'b0};

  assign done      = (cnt_q == CNT_W'(1));

  // NOTE: every register, counter included, is cleared by the asynchronous
  // reset so an operation aborted by reset leaves no residue behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      sh_q    <= din;
      cnt_q   <= mag;
      right_q <= dir_right;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      sh_q    <= data_next;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

endmodule : alu_iter_shift

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked, parametrised sequential ALU sitting between decode and
// register-file write-back. Same opcode encoding and flag layout as the
// 16-bit combinational ALU, with a registered result, valid/ready flow
// control, sticky flags and iterative multi-cycle shifts.
//
// Build option
//   ALU_SEQ_MUL_EN  when defined, opcode 0x0E is an unsigned shift-add
//                   multiply (WIDTH iterations). When undefined the MUL
//                   datapath is absent and 0x0E decodes as an unknown opcode.
//
// Parameters
//   WIDTH     operand/result width (>= 4)
//   CNT_W     iteration counter width
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  request accepted this cycle (state IDLE)
//   a          in   Rdest operand
//   b          in   Rsrc operand / signed shift amount
//   op         in   8-bit opcode
//   out_valid  out  result held (state DONE)
//   out_ready  in   consumer takes result
//   result     out  registered result
//   flags      out  {N, Z, F, L, C}, registered and sticky
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam int               MSB     = WIDTH - 1;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;

  logic             accept;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_result;
  logic [4:0]       sc_flags;

  logic [WIDTH-1:0] b_abs;
  logic [CNT_W-1:0] shift_mag;
  logic             shift_start;
  logic             shift_done;
  logic [WIDTH-1:0] shift_next;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Shift magnitude: |b| saturated at WIDTH. The most negative b negates to
  // itself, which read unsigned is 2^(WIDTH-1) and still saturates correctly.
  // ---------------------------------------------------------------------------
  assign b_abs       = b[MSB] ? (-b) : b;
  assign shift_mag   = (b_abs >= WIDTH_V) ? CNT_W'(WIDTH) : b_abs[CNT_W-1:0];
  assign shift_start = accept && is_shift_op(op) && (shift_mag != '0);

  alu_iter_shift #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (shift_start),
    .din       (a),
    .mag       (shift_mag),
    .dir_right (b[MSB]),
    .arith     (is_arith_op(op)),
    .done      (shift_done),
    .data_next (shift_next)
  );

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs and captured on the
  // accept edge (which is also the edge entering DONE for these ops).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the case can leave a value unassigned and infer a latch.
    add_full  = {1'b0, a} + {1'b0, b};
    sub_full  = {1'b0, a} - {1'b0, b};
    sc_result = '0;
    sc_flags  = flags_q;
    unique case (op)
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_ADD: begin
        sc_result        = add_full[WIDTH-1:0];
        sc_flags[FLAG_C] = add_full[WIDTH];
        sc_flags[FLAG_F] = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_result        = sub_full[WIDTH-1:0];
        // The zero-extended difference goes negative exactly when a < b.
        sc_flags[FLAG_C] = sub_full[WIDTH];
        sc_flags[FLAG_F] = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      OP_CMP: begin
        sc_result        = sub_full[WIDTH-1:0];
        sc_flags[FLAG_Z] = (a == b);
        sc_flags[FLAG_L] = (a < b);
        sc_flags[FLAG_N] = ($signed(a) < $signed(b));
      end
      // Only reached with a zero magnitude: the operand passes through.
      OP_LSH, OP_ASHU: sc_result = a;
      default: sc_result = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // ---------------------------------------------------------------------------
  // Shift-add multiplier. prod_q starts as {0, multiplier}; each iteration
  // adds the multiplicand into the upper half when the LSB is set and shifts
  // the whole (carry, product) right by one. After WIDTH steps prod_q holds
  // the full 2*WIDTH-bit product.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   mul_cnt_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               mul_done;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  assign mul_done = (mul_cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q    <= '0;
      mcand_q   <= '0;
      mul_cnt_q <= '0;
    end else if (accept && (op == OP_MUL)) begin
      prod_q    <= {{WIDTH{1'b0}}, b};
      mcand_q   <= a;
      mul_cnt_q <= CNT_W'(WIDTH);
    end else if (state_q == MUL) begin
      prod_q    <= mul_next;
      mul_cnt_q <= mul_cnt_q - CNT_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Controller: state, registered result and sticky flags. Flags change only
  // on the edge entering DONE.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_shift_op(op) && (shift_mag != '0)) begin
              state_q <= SHIFT;
`ifdef ALU_SEQ_MUL_EN
            end else if (op == OP_MUL) begin
              state_q <= MUL;
`endif
            end else begin
              state_q  <= DONE;
              result_q <= sc_result;
              flags_q  <= sc_flags;
            end
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state_q  <= DONE;
            result_q <= shift_next;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (mul_done) begin
            state_q          <= DONE;
            result_q         <= mul_next[WIDTH-1:0];
            flags_q[FLAG_C]  <= |mul_next[2*WIDTH-1:WIDTH];
            flags_q[FLAG_F]  <= |mul_next[2*WIDTH-1:WIDTH];
            flags_q[FLAG_Z]  <= (mul_next[WIDTH-1:0] == '0);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : alu_seq
